// File: rtl/count_display_pkg.sv
// -----------------------------------------------------------------------------
// count_display_pkg
// Shared definitions for the counter / Fibonacci / multiplexed 7-segment lab:
//   - bcd_state_e : states of the sequential double-dabble converter
//   - SEG_BLANK   : active-low "all segments off" pattern
//   - seg_decode  : BCD code -> active-low {g,f,e,d,c,b,a}; codes >= 10 blank
//   - is_fib      : Fibonacci membership test for a value below 2^width
// -----------------------------------------------------------------------------
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Walks the Fibonacci sequence (fib(0)..fib(24) covers every 16-bit value)
  // and reports whether value is a member below 2^width.
  function automatic logic is_fib(input logic [15:0] value, input int unsigned width);
    logic [16:0] a;
    logic [16:0] b;
    logic [16:0] t;
    logic        hit;
    a   = 17'd0;
    b   = 17'd1;
    hit = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if ((a < (17'd1 << width)) && (a == {1'b0, value})) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
      t = a + b;
      a = b;
      b = t;
    end
    return hit;
  endfunction

endpackage

// File: rtl/count_display_mux_if.sv
// -----------------------------------------------------------------------------
// count_display_mux_if
// Board-side signal bundle of the counter lab top.
//   ON_OFF   : 1 = run and display, 0 = freeze/blank
//   up_down  : count direction (1 = up)
//   count    : current counter value (WIDTH bits)
//   fib_out  : registered Fibonacci flag for count
//   bcd_out  : active-low segments {g,f,e,d,c,b,a} of the selected digit
//   anode    : active-low one-hot digit select (DIGITS bits)
// master = board / stimulus side, slave = count_display_mux.
// -----------------------------------------------------------------------------
interface count_display_mux_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic              ON_OFF;
  logic              up_down;
  logic [WIDTH-1:0]  count;
  logic              fib_out;
  logic [6:0]        bcd_out;
  logic [DIGITS-1:0] anode;

  modport master (
    output ON_OFF, up_down,
    input  count, fib_out, bcd_out, anode
  );

  modport slave (
    input  ON_OFF, up_down,
    output count, fib_out, bcd_out, anode
  );
endinterface

// File: rtl/count_display_mux_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter. Whenever start is high in IDLE and bin
// differs from the last value it latched, it latches bin, runs WIDTH
// add-3/shift cycles in SHIFT, then spends one cycle in DONE with the result
// on bcd. A bin change during SHIFT is picked up by the next IDLE compare.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bin          : binary value to convert (WIDTH bits)
//   start        : arms conversion launch
//   bcd          : BCD working register, DIGITS nibbles, digit 0 in [3:0]
//   done         : high for the cycle in which bcd holds a finished result
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import count_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    bin,
  input  logic                start,
  output logic [4*DIGITS-1:0] bcd,
  output logic                done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

  bcd_state_e       state_r;
  bcd_state_e       state_s;
  logic [WIDTH-1:0] snap_r;
  logic [WIDTH-1:0] sh_r;
  logic [BW-1:0]    bcd_r;
  logic [CW-1:0]    cnt_r;
  logic [BW-1:0]    adj_s;
  logic [BW-1:0]    bcd_sh_s;
  logic [WIDTH-1:0] sh_sh_s;
  logic             launch_s;

  assign launch_s = start && (bin != snap_r);

  // Add 3 to every nibble >= 5 so the following shift carries correctly.
  always_comb begin
    adj_s = bcd_r;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_r[4*d +: 4] >= 4'd5) begin
        adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
      end else begin
        adj_s[4*d +: 4] = bcd_r[4*d +: 4];
      end
    end
  end

  // One double-dabble step: {bcd, shift register} shifted left by one.
  always_comb begin
    bcd_sh_s = {adj_s[BW-2:0], sh_r[WIDTH-1]};
    sh_sh_s  = {sh_r[WIDTH-2:0], 1'b0};
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_SHIFT) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Conversion datapath: latch on launch, shift while in SHIFT.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_r <= {WIDTH{1'b0}};
      sh_r   <= {WIDTH{1'b0}};
      bcd_r  <= {BW{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            snap_r <= bin;
            sh_r   <= bin;
            bcd_r  <= {BW{1'b0}};
            cnt_r  <= {CW{1'b0}};
          end
        end
        SHIFT: begin
          sh_r  <= sh_sh_s;
          bcd_r <= bcd_sh_s;
          cnt_r <= cnt_r + CW'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bcd  = bcd_r;
  assign done = (state_r == DONE);

endmodule

// File: rtl/count_display_mux.sv
// -----------------------------------------------------------------------------
// count_display_mux
// Board-level top of the counter lab: prescaled W-bit up/down counter,
// registered Fibonacci flag, sequential BCD conversion and a time-multiplexed
// DIGITS-digit active-low 7-segment display.
// Ports:
//   clock  : system clock, all state on the rising edge
//   reset  : synchronous active-high reset
//   bus    : count_display_mux_if.slave (ON_OFF, up_down in;
//            count, fib_out, bcd_out, anode out)
// Build option: LEADING_ZERO_BLANK_EN blanks leading-zero digit slots
// (digit 0 never blanked); undefined shows all digits including zeros.
// -----------------------------------------------------------------------------
module count_display_mux
  import count_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 1,
  parameter int SCAN_DIV = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  count_display_mux_if.slave   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;

  logic [PW-1:0]     presc_r;
  logic              tick_s;
  logic [WIDTH-1:0]  count_r;
  logic              fib_r;
  logic [SW-1:0]     scan_cnt_r;
  logic [IW-1:0]     scan_idx_r;
  logic [BW-1:0]     digits_r;
  logic [BW-1:0]     bcd_s;
  logic              done_s;
  logic [3:0]        code_s;
  logic              blank_s;
  logic [DIGITS-1:0] anode_s;
  logic [6:0]        seg_s;
  logic [DIGITS-1:0] anode_r;
  logic [6:0]        seg_r;

  // ON_OFF gates the tick directly, so a tick coinciding with ON_OFF
  // falling is dropped.
  assign tick_s = bus.ON_OFF && (presc_r == PW'(TICK_DIV - 1));

  // Prescaler: counts while running, holds while off.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
    end else if (bus.ON_OFF) begin
      if (tick_s) begin
        presc_r <= {PW{1'b0}};
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Up/down counter; wraps naturally modulo 2^WIDTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (tick_s) begin
      if (bus.up_down) begin
        count_r <= count_r + WIDTH'(1);
      end else begin
        count_r <= count_r - WIDTH'(1);
      end
    end
  end

  // Fibonacci flag, forced low while the display is off.
  always_ff @(posedge clock) begin
    if (reset) begin
      fib_r <= 1'b0;
    end else begin
      fib_r <= bus.ON_OFF && is_fib(16'(count_r), WIDTH);
    end
  end

  // The converter keeps itself in step with count: always armed, it relaunches
  // whenever count differs from what it last converted.
  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .bin   (count_r),
    .start (1'b1),
    .bcd   (bcd_s),
    .done  (done_s)
  );

  // Display digits take a finished conversion only.
  always_ff @(posedge clock) begin
    if (reset) begin
      digits_r <= {BW{1'b0}};
    end else if (done_s) begin
      digits_r <= bcd_s;
    end
  end

  // Scan timer and digit index; both freeze while off.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt_r <= {SW{1'b0}};
      scan_idx_r <= {IW{1'b0}};
    end else if (bus.ON_OFF) begin
      if (scan_cnt_r == SW'(SCAN_DIV - 1)) begin
        scan_cnt_r <= {SW{1'b0}};
        if (scan_idx_r == IW'(DIGITS - 1)) begin
          scan_idx_r <= {IW{1'b0}};
        end else begin
          scan_idx_r <= scan_idx_r + IW'(1);
        end
      end else begin
        scan_cnt_r <= scan_cnt_r + SW'(1);
      end
    end
  end

  // Pick the BCD code of the selected digit.
  always_comb begin
    code_s = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (scan_idx_r == IW'(d)) begin
        code_s = digits_r[4*d +: 4];
      end else begin
        code_s = code_s;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_s;
  logic              zero_run_s;

  // A slot is a leading zero when it and every more-significant digit are 0;
  // digit 0 always shows.
  always_comb begin
    zero_run_s = 1'b1;
    lz_s       = {DIGITS{1'b0}};
    blank_s    = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zero_run_s = zero_run_s && (digits_r[4*d +: 4] == 4'd0);
      if (d != 0) begin
        lz_s[d] = zero_run_s;
      end else begin
        lz_s[d] = 1'b0;
      end
    end
    for (int d = 0; d < DIGITS; d++) begin
      if (scan_idx_r == IW'(d)) begin
        blank_s = lz_s[d];
      end else begin
        blank_s = blank_s;
      end
    end
  end
`else
  assign blank_s = 1'b0;
`endif

  // Next anode/segment values; everything dark while off.
  always_comb begin
    anode_s = {DIGITS{1'b1}};
    seg_s   = SEG_BLANK;
    if (bus.ON_OFF) begin
      anode_s = ~(DIGITS'(1) << scan_idx_r);
      if (blank_s) begin
        seg_s = SEG_BLANK;
      end else begin
        seg_s = seg_decode(code_s);
      end
    end else begin
      anode_s = {DIGITS{1'b1}};
      seg_s   = SEG_BLANK;
    end
  end

  // Registered display drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode_r <= {DIGITS{1'b1}};
      seg_r   <= SEG_BLANK;
    end else begin
      anode_r <= anode_s;
      seg_r   <= seg_s;
    end
  end

  assign bus.count   = count_r;
  assign bus.fib_out = fib_r;
  assign bus.bcd_out = seg_r;
  assign bus.anode   = anode_r;

endmodule

// File: tb/tb_count_display_mux.sv
// -----------------------------------------------------------------------------
// tb_count_display_mux
// Directed bench for count_display_mux with WIDTH=8, DIGITS=3, TICK_DIV=1,
// SCAN_DIV=4. Inputs change and outputs are sampled on the falling edge.
// The display is read through short "windows": count is frozen (ON_OFF=0)
// long enough for conversion to settle, then ON_OFF is raised for 11 cycles
// while up_down alternates; the old digits stay visible for exactly those
// cycles and count ends one step away from where it started.
// -----------------------------------------------------------------------------
module tb_count_display_mux;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  count_display_mux_if #(.WIDTH(8), .DIGITS(3)) bus_if ();

  count_display_mux #(
    .WIDTH    (8),
    .DIGITS   (3),
    .TICK_DIV (1),
    .SCAN_DIV (4)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic bit tb_fib(input int x);
    case (x)
      0, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // Expected segments of decimal position p of value v.
  function automatic logic [6:0] exp_digit(input int v, input int p);
    int d[3];
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = v / 100;
`ifdef LEADING_ZERO_BLANK_EN
    if (p == 2 && d[2] == 0) return 7'h7F;
    if (p == 1 && d[2] == 0 && d[1] == 0) return 7'h7F;
`endif
    return exp_seg(d[p]);
  endfunction

  function automatic logic [2:0] next_anode(input logic [2:0] a);
    case (a)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      3'b011:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_until(input int v);
    int i;
    i = 0;
    while (bus_if.count != 8'(v) && i < 600) begin
      @(negedge clk);
      i++;
    end
    chk("reach_count", 32'(bus_if.count), 32'(v));
  endtask

  task automatic check_frozen(input int v);
    chk("off_count", 32'(bus_if.count), 32'(v));
    chk("off_anode", 32'(bus_if.anode), 32'h7);
    chk("off_bcd", 32'(bus_if.bcd_out), 32'h7F);
    chk("off_fib", 32'(bus_if.fib_out), 32'h0);
  endtask

  task automatic window(input int v, input bit up_first);
    bit ud;
    int first;
    ud    = up_first;
    first = up_first ? (v + 1) % 256 : (v + 255) % 256;
    bus_if.ON_OFF  = 1'b1;
    bus_if.up_down = ud;
    for (int s = 0; s < 11; s++) begin
      @(negedge clk);
      if (s == 0) chk("win_first_step", 32'(bus_if.count), 32'(first));
      if (s == 1) chk("win_fib", 32'(bus_if.fib_out), 32'(tb_fib(first)));
      case (bus_if.anode)
        3'b110:  chk("win_digit0", 32'(bus_if.bcd_out), 32'(exp_digit(v, 0)));
        3'b101:  chk("win_digit1", 32'(bus_if.bcd_out), 32'(exp_digit(v, 1)));
        3'b011:  chk("win_digit2", 32'(bus_if.bcd_out), 32'(exp_digit(v, 2)));
        default: chk("win_anode", 32'(bus_if.anode), 32'h6);
      endcase
      ud = ~ud;
      bus_if.up_down = ud;
    end
    bus_if.ON_OFF = 1'b0;
    step(30);
  endtask

  initial begin
    logic [2:0] prev;
    int         last_chg;
    int         n_chg;

    // Reset held for two cycles.
    reset          = 1'b1;
    bus_if.ON_OFF  = 1'b0;
    bus_if.up_down = 1'b1;
    step(2);
    chk("rst_count", 32'(bus_if.count), 32'h0);
    chk("rst_fib", 32'(bus_if.fib_out), 32'h0);
    chk("rst_bcd", 32'(bus_if.bcd_out), 32'h7F);
    chk("rst_anode", 32'(bus_if.anode), 32'h7);

    // Count up from 0; fib_out lags count by one cycle.
    reset         = 1'b0;
    bus_if.ON_OFF = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      chk("up_count", 32'(bus_if.count), 32'(k));
      chk("up_fib", 32'(bus_if.fib_out), 32'(tb_fib(k - 1)));
    end

    // fib flag for 233 (member) and 234 (not a member).
    run_until(234);
    chk("fib_233", 32'(bus_if.fib_out), 32'h1);
    step(1);
    chk("fib_234", 32'(bus_if.fib_out), 32'h0);

    // Freeze at 255.
    run_until(255);
    bus_if.ON_OFF = 1'b0;
    step(1);
    check_frozen(255);
    step(30);

    // 255 on display, wrap to 0, then 000, then down from 0 to 255.
    window(255, 1'b1);
    window(0, 1'b0);
    window(255, 1'b1);

    // Pause at 13, resume to 14, then check the scan order and period.
    bus_if.ON_OFF  = 1'b1;
    bus_if.up_down = 1'b1;
    run_until(13);
    bus_if.ON_OFF = 1'b0;
    step(1);
    check_frozen(13);
    step(3);
    chk("hold_13", 32'(bus_if.count), 32'd13);
    bus_if.ON_OFF = 1'b1;
    step(1);
    chk("resume_14", 32'(bus_if.count), 32'd14);
    prev = bus_if.anode;
    chk("scan_valid", 32'(prev == 3'b110 || prev == 3'b101 || prev == 3'b011), 32'h1);
    last_chg = -1;
    n_chg    = 0;
    for (int s = 1; s <= 12; s++) begin
      step(1);
      if (bus_if.anode != prev) begin
        n_chg++;
        chk("scan_order", 32'(bus_if.anode), 32'(next_anode(prev)));
        if (last_chg >= 0) chk("scan_period", 32'(s - last_chg), 32'd4);
        last_chg = s;
        prev     = bus_if.anode;
      end
    end
    chk("scan_changes", 32'(n_chg), 32'd3);

    // Reset while the converter is busy (count moving every cycle).
    step(5);
    reset = 1'b1;
    step(1);
    chk("mid_rst_count", 32'(bus_if.count), 32'h0);
    chk("mid_rst_fib", 32'(bus_if.fib_out), 32'h0);
    chk("mid_rst_bcd", 32'(bus_if.bcd_out), 32'h7F);
    chk("mid_rst_anode", 32'(bus_if.anode), 32'h7);
    bus_if.ON_OFF = 1'b0;
    step(1);
    reset = 1'b0;
    step(30);
    window(0, 1'b1);

    // Count of 7: leading zeros shown or blanked depending on the build.
    bus_if.ON_OFF  = 1'b1;
    bus_if.up_down = 1'b1;
    run_until(7);
    bus_if.ON_OFF = 1'b0;
    step(30);
    window(7, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_display_mux.md
# count_display_mux

Parametrised successor of the 4-bit counter / Fibonacci-flag / single-digit 7-segment demo. It contains a W-bit up/down counter with an on/off enable and a prescaled count tick. It computes a registered Fibonacci-membership flag and converts the count to BCD with a sequential double-dabble engine. It drives a time-multiplexed multi-digit 7-segment display, and is the board-level top for the counter lab.

## Interface
- WIDTH, 8: counter width in bits, 2..16.
- DIGITS, 3: displayed decimal digits; must satisfy 10^DIGITS ≥ 2^WIDTH.
- TICK_DIV, 1: clock cycles per count step. 1 means step every enabled cycle.
- SCAN_DIV, 4: clock cycles per display digit slot, ≥1.
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- ON_OFF  in  1  1 = run and display; 0 = freeze count, blank display, clear fib_out.
- up_down  in  1  1 = count up, 0 = count down; sampled on each tick.
- count  out  WIDTH  current counter value.
- fib_out  out  1  registered: count is a Fibonacci number.
- bcd_out  out  7  active-low segments {g,f,e,d,c,b,a} for the digit currently selected.
- anode  out  DIGITS  active-low one-hot digit select.

## Operation
- Reset values: count=0, fib_out=0, bcd_out=7'h7F, anode=all 1, prescaler=0, scan index=0, BCD FSM=IDLE, display digits=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while ON_OFF=1 and emits a tick at the wrap.
  - Holds its value while ON_OFF=0.
- Counter:
  - On a tick, count ±1 according to up_down.
  - Wraps modulo 2^WIDTH: max+1 → 0 and 0-1 → max.
- Fibonacci flag:
  - fib_out = (ON_OFF && count ∈ {0,1,2,3,5,8,13,21,...} below 2^WIDTH), registered.
- BCD FSM states:
  - IDLE: when the snapshot differs from count, latch count into the shift register, clear the BCD register, go to SHIFT.
  - SHIFT: runs exactly WIDTH cycles; each cycle adds 3 to any BCD nibble ≥5, then shifts left one bit.
  - DONE: copies the BCD register into the display digits, then returns to IDLE.
- Count changes while the FSM is in SHIFT are not lost. Returning to IDLE re-compares against the latest count and restarts the conversion.
- Scan:
  - Index advances every SCAN_DIV cycles and wraps DIGITS-1 → 0.
  - anode[i]=0 only for the selected i; bcd_out is the segment pattern of digit i.
  - Digit 0 is the least-significant digit.
- ON_OFF=0:
  - anode=all 1 and bcd_out=7'h7F from the next cycle.
  - count, prescaler and scan index hold.
  - The BCD FSM finishes any conversion in progress.

## Timing
- count changes 1 cycle after the prescaler tick.
- fib_out follows count with 1 cycle latency.
- Display digits update WIDTH+2 cycles after count changes, when the FSM was IDLE.
- Display blanking and unblanking follow ON_OFF with 1 cycle latency.
- Reset asserted mid-conversion aborts the conversion to IDLE.
- Simultaneous reset and ON_OFF: reset wins.
- The prescaler tick and an ON_OFF falling edge may occur in the same cycle. The tick is suppressed because ON_OFF is sampled first.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - A digit slot is blanked (bcd_out=7'h7F, its anode still driven) when that digit and all more-significant digits are 0.
  - Digit 0 is never blanked.
- LEADING_ZERO_BLANK_EN undefined: every digit always shows its value, including leading zeros.

## Structure
- Shared package count_display_pkg holds:
  - the BCD FSM state enum (IDLE, SHIFT, DONE);
  - the 7-segment decode function for codes 0–9, with codes ≥10 mapping to 7'h7F;
  - an is_fib(value, width) function evaluated against the Fibonacci sequence.
- One sub-module: bin2bcd_seq (parameters WIDTH, DIGITS), containing the double-dabble FSM.
  - Inputs: clock, reset, bin, start.
  - Outputs: bcd, done.
- The top level holds the prescaler, counter, fib register and scan logic.

## Test plan
Bench uses WIDTH=8, DIGITS=3, TICK_DIV=1, SCAN_DIV=4.
- Reset held 2 cycles, then ON_OFF=1, up_down=1 → count 0,1,2,...; fib_out=1 for count 1,2,3,5,8 and 0 for count 4,6,7.
- Count runs up to 255 → wraps to 0. After WIDTH+2 cycles the digits read 2,5,5 and then 0,0,0; fib_out=1 at 0 and at 233.
- up_down=0 from count=0 → count=255 on the next tick; display converges to 255.
- ON_OFF=0 at count=13 → count stays at 13, anode=3'b111, fib_out=0. ON_OFF back to 1 → count resumes 14, and anode scans 110→101→011 every 4 cycles.
- Conversion overlap: count changes every cycle with TICK_DIV=1. Once the count is frozen, the final display equals the frozen count with no stale digits.
- With LEADING_ZERO_BLANK_EN defined and count=7 → digits 2 and 1 show 7'h7F and digit 0 shows "7". Without the macro → "007".
- Reset asserted during SHIFT → all outputs return to their reset values on the next cycle.
